// File: rtl/busca_pkg.sv
// busca_pkg: shared types and constants for the instruction-fetch stage
package busca_pkg;
  localparam int LARGURA_PADRAO = 32;
  localparam logic [31:0] RESET_PC_PADRAO = 32'h0000_0000;
  localparam logic [31:0] INCREMENTO_PC = 32'd4;
  typedef enum logic [1:0] {OCIOSO, ESPERA, DESCARTE} estado_t;
  typedef struct packed {
    logic [LARGURA_PADRAO-1:0] endereco;
    logic [LARGURA_PADRAO-1:0] instrucao;
  } entrada_t;
endpackage

// File: rtl/fila_instrucoes.sv
// fila_instrucoes: synchronous FIFO of fetched {pc, instruction} entries with flush
module fila_instrucoes
  import busca_pkg::*;
#(
  parameter int PROFUNDIDADE = 2,
  parameter int AW = $clog2(PROFUNDIDADE)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  entrada_t      entrada,
  input  logic          pop,
  output entrada_t      cabeca,
  output logic          vazia,
  output logic [AW:0]   contagem
);
  localparam int CW = AW + 1;
  entrada_t mem_q [PROFUNDIDADE];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic push_ok, pop_ok, cheia;
  assign vazia    = cnt_q == '0;
  assign cheia    = cnt_q == CW'(PROFUNDIDADE);
  assign pop_ok   = pop & ~vazia;
  assign push_ok  = push & (~cheia | pop_ok);
  assign cabeca   = mem_q[rd_q];
  assign contagem = cnt_q;
  // next pointers and count; flush empties the queue regardless of push/pop
  always_comb begin
    wr_d  = flush ? '0 : wr_q + AW'(push_ok);
    rd_d  = flush ? '0 : rd_q + AW'(pop_ok);
    cnt_d = flush ? '0 : cnt_q + CW'(push_ok) - CW'(pop_ok);
  end
  // pointer/count registers and entry storage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < PROFUNDIDADE; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push_ok && !flush) mem_q[wr_q] <= entrada;
    end
  end
endmodule

// File: rtl/busca_instrucao.sv
// busca_instrucao: fetch FSM, fetch PC and memory req/ack handshake feeding a small FIFO
module busca_instrucao
  import busca_pkg::*;
#(
  parameter int                 LARGURA      = LARGURA_PADRAO,
  parameter logic [LARGURA-1:0] RESET_PC     = LARGURA'(RESET_PC_PADRAO),
  parameter int                 PROFUNDIDADE = 2
) (
  input  logic               clock,
  input  logic               reset,
  output logic               mem_req,
  output logic [LARGURA-1:0] mem_endereco,
  input  logic               mem_ack,
  input  logic [LARGURA-1:0] mem_dado,
  input  logic               desvio,
  input  logic [LARGURA-1:0] endereco_desvio,
  output logic               instr_valida,
  output logic [LARGURA-1:0] instrucao_saida,
  output logic [LARGURA-1:0] endereco_saida,
  input  logic               instr_pronta
);
  localparam int CW = $clog2(PROFUNDIDADE) + 1;
  estado_t estado_q, estado_d;
  logic [LARGURA-1:0] pc_q, pc_d, endereco_q, endereco_d, alvo, pc_mais;
  logic req_q, req_d, push, pop, vazia, cabe;
  logic [CW-1:0] contagem, ocup_prox;
  entrada_t cabeca;
  assign alvo      = endereco_desvio & ~LARGURA'(3);
  assign pc_mais   = pc_q + LARGURA'(INCREMENTO_PC);
  assign pop       = instr_valida & instr_pronta;
  assign push      = estado_q == ESPERA && mem_ack && !desvio;
  assign ocup_prox = desvio ? '0 : contagem + CW'(push) - CW'(pop);
  assign cabe      = ocup_prox < CW'(PROFUNDIDADE);
  fila_instrucoes #(.PROFUNDIDADE(PROFUNDIDADE)) u_fila (
    .clock    (clock),
    .reset    (reset),
    .flush    (desvio),
    .push     (push),
    .entrada  ({pc_q, mem_dado}),
    .pop      (pop),
    .cabeca   (cabeca),
    .vazia    (vazia),
    .contagem (contagem)
  );
  assign mem_req         = req_q;
  assign mem_endereco    = endereco_q;
  assign instr_valida    = ~vazia;
  assign instrucao_saida = cabeca.instrucao;
  assign endereco_saida  = cabeca.endereco;
  // next state: redirect wins; a response landing in DESCARTE or alongside desvio is dropped
  always_comb begin
    estado_d   = estado_q;
    pc_d       = pc_q;
    endereco_d = endereco_q;
    req_d      = req_q;
    case (estado_q)
      OCIOSO: begin
        if (desvio) begin
          pc_d       = alvo;
          endereco_d = alvo;
          estado_d   = ESPERA;
          req_d      = 1'b1;
        end else if (cabe) begin
          endereco_d = pc_q;
          estado_d   = ESPERA;
          req_d      = 1'b1;
        end
      end
      ESPERA: begin
        if (desvio) begin
          pc_d       = alvo;
          endereco_d = mem_ack ? alvo : endereco_q;
          estado_d   = mem_ack ? ESPERA : DESCARTE;
        end else if (mem_ack) begin
          pc_d       = pc_mais;
          endereco_d = pc_mais;
          estado_d   = cabe ? ESPERA : OCIOSO;
          req_d      = cabe;
        end
      end
      DESCARTE: begin
        pc_d = desvio ? alvo : pc_q;
        if (mem_ack) begin
          endereco_d = pc_d;
          estado_d   = ESPERA;
        end
      end
      default: begin
        estado_d = OCIOSO;
        req_d    = 1'b0;
      end
    endcase
  end
  // FSM, fetch PC and registered memory request
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= OCIOSO;
      pc_q       <= RESET_PC;
      endereco_q <= RESET_PC;
      req_q      <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      pc_q       <= pc_d;
      endereco_q <= endereco_d;
      req_q      <= req_d;
    end
  end
endmodule

// File: doc/busca_instrucao.md
Name: busca_instrucao

Overview:
Instruction-fetch stage that sits directly upstream of the core's decode and execute datapath.
- Owns the fetch PC and drives instruction memory through a req/ack handshake that tolerates variable latency.
- Buffers fetched words, each with its PC, in a small FIFO.
- Presents them downstream with a valid/ready handshake.
- Honours branch redirects from the execute side by flushing the FIFO and discarding any in-flight response.

Parameters:
RESET_PC, 32'h00000000, fetch address loaded on reset.
PROFUNDIDADE, 2, FIFO depth in entries; power of 2, minimum 2.
LARGURA, 32, instruction and address width.

Ports:
clock  in  1  rising-edge clock.
reset  in  1  asynchronous, active-low reset.
mem_req  out  1  instruction-memory request; held until mem_ack.
mem_endereco  out  32  request address; stable while mem_req=1.
mem_ack  in  1  memory accepts request and returns mem_dado this cycle; may be high in the same cycle mem_req rises.
mem_dado  in  32  instruction word, valid when mem_req & mem_ack.
desvio  in  1  one-cycle redirect pulse.
endereco_desvio  in  32  redirect target; bits [1:0] ignored (forced 00).
instr_valida  out  1  FIFO head holds a valid instruction.
instrucao_saida  out  32  FIFO head instruction.
endereco_saida  out  32  PC of the head instruction.
instr_pronta  in  1  consumer accepts head when instr_valida & instr_pronta.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc_busca=RESET_PC; state OCIOSO; FIFO empty.
  - mem_req=0; mem_endereco=RESET_PC; instr_valida=0; instrucao_saida=0; endereco_saida=0.
  - An outstanding memory request is abandoned; the memory must tolerate this.
- FSM states: OCIOSO, ESPERA, DESCARTE.
  - OCIOSO: if occupancy_next < PROFUNDIDADE, go to ESPERA with mem_req=1 and mem_endereco=pc_busca.
  - ESPERA: on mem_ack, push {pc_busca, mem_dado} and set pc_busca += 4 (wraps mod 2^32).
    - If occupancy_next after the push is < PROFUNDIDADE, stay in ESPERA with mem_req=1 and the new address (back-to-back, 1 fetch/cycle).
    - Otherwise go to OCIOSO with mem_req=0.
  - DESCARTE: mem_req stays 1 with the old address until mem_ack. The response is dropped. Then go to ESPERA at pc_busca (the target).
- At most one outstanding request. mem_req and mem_endereco are registered. mem_endereco never changes while mem_req=1 and mem_ack=0.
- occupancy_next is the FIFO count after this cycle's push and pop.
- Downstream port:
  - instr_valida = FIFO not empty; head fields come straight from FIFO registers.
  - Pop on instr_valida & instr_pronta.
  - Push and pop in the same cycle are allowed when the FIFO is full.
- Redirect (desvio=1), highest priority:
  - At the edge: FIFO flushed (count=0) and pc_busca = {endereco_desvio[31:2], 2'b00}.
  - A pop in the same cycle is treated as a completed transfer.
  - If ESPERA and mem_ack=0: go to DESCARTE.
  - If ESPERA and mem_ack=1: the response is dropped, not pushed. Next cycle, ESPERA at the target.
  - If OCIOSO: next cycle, ESPERA at the target.
  - If DESCARTE: stay in DESCARTE; only the target is updated.
  - instr_valida=0 in the cycle after desvio.
- Latency with zero-wait memory (mem_ack tied 1):
  - First mem_req at the first edge after reset release.
  - instr_valida 1 cycle later.
  - Redirect-to-valid is 2 cycles.
- FIFO full with instr_pronta=0: mem_req drops; no word is ever lost or duplicated.

Decomposition:
- Package busca_pkg holds:
  - state enum {OCIOSO, ESPERA, DESCARTE};
  - default RESET_PC;
  - constant INCREMENTO_PC = 32'd4;
  - entry struct {endereco[31:0], instrucao[31:0]}.
- Sub-module fila_instrucoes holds the synchronous FIFO: PROFUNDIDADE entries, flush input, count output, async active-low reset.
- busca_instrucao contains the FSM, pc_busca and the memory handshake.

Test Plan:
- Reset release, mem_ack=1, instr_pronta=1 -> instr_valida from cycle 2 with endereco_saida 0x0, 0x4, 0x8 on consecutive cycles; instrucao_saida equals the memory words.
- instr_pronta=0 for 6 cycles, zero-wait memory -> exactly 2 entries buffered (0x0, 0x4), then mem_req=0. On release, 0x0, 0x4, 0x8 are delivered with no gap or duplicate.
- mem_ack delayed 3 cycles per request -> mem_endereco stable while waiting; output PCs are 0x0, 0x4, 0x8 in order.
- desvio=1 with endereco_desvio=0x100 while a request for 0x8 is pending, ack arriving 2 cycles later -> 0x8 data dropped; next request at 0x100; first valid output endereco_saida=0x100.
- desvio with ack in the same cycle, target 0x43 -> target forced to 0x40; FIFO empty the next cycle; 0x40 appears 2 cycles after desvio.
- reset asserted mid-ESPERA with FIFO holding 1 entry -> all outputs immediately at reset values; after release, fetch restarts at RESET_PC.
